// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared funct3 codes, store FSM states and lane helpers for the data-memory path
// Used by both the default read-modify-write build and the DM_BYTE_STROBE_EN build.
package dm_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, ERR} dm_state_t;

   // Lowest byte lane touched by an access; halves always start on an even lane.
   function automatic logic [1:0] lane_idx(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_SB:   return addr_lo;
         F3_SH:   return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic store_err(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_SB:   return 1'b0;
         F3_SH:   return addr_lo[0];
         F3_SW:   return |addr_lo;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] wdata, input logic [2:0] funct3);
      case (funct3)
         F3_SB:   return {4{wdata[7:0]}};
         F3_SH:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/dm_store_merge.sv
// rtl/dm_store_merge.sv - inserts right-justified store data into its byte lanes of an old word
// Inverse of the load masker: lanes outside the byte-enable mask keep the old word's bytes.
module dm_store_merge
   import dm_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] st_data,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] merged,
   output logic [3:0]  be
);

   logic [3:0]  base;
   logic [31:0] rep;
   logic [31:0] bitmask;

   always_comb begin
      case (funct3)
         F3_SB:   base = 4'b0001;
         F3_SH:   base = 4'b0011;
         default: base = 4'b1111;
      endcase
      be      = base << lane_idx(funct3, addr_lo);
      rep     = replicate(st_data, funct3);
      bitmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      merged  = (old_word & ~bitmask) | (rep & bitmask);
   end

endmodule

// File: rtl/dm_store_unit.sv
// rtl/dm_store_unit.sv - SB/SH/SW store unit: direct word writes, read-modify-write for sub-words
// Define DM_BYTE_STROBE_EN to add mem_be and write every legal store in a single cycle.
module dm_store_unit
   import dm_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_wdata,
   input  logic [2:0]        st_funct3,
   output logic              st_done,
   output logic              st_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
`ifdef DM_BYTE_STROBE_EN
   output logic [3:0]        mem_be,
`endif
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rvalid
);

   dm_state_t   state;
   logic [31:0] merged;
   logic [3:0]  merge_be;

`ifdef DM_BYTE_STROBE_EN
   logic unused_ok;
   assign unused_ok = ^{st_addr[31:MEM_AW+2], mem_rdata};

   // Strobe build merges straight from the request; replicated data fills every lane.
   dm_store_merge u_merge (
      .old_word (replicate(st_wdata, st_funct3)),
      .st_data  (st_wdata),
      .addr_lo  (st_addr[1:0]),
      .funct3   (st_funct3),
      .merged   (merged),
      .be       (merge_be)
   );
`else
   logic        unused_ok;
   logic [31:0] wdata_q;
   logic [1:0]  addr_lo_q;
   logic [2:0]  funct3_q;
   assign unused_ok = ^{st_addr[31:MEM_AW+2], merge_be};

   dm_store_merge u_merge (
      .old_word (mem_rdata),
      .st_data  (wdata_q),
      .addr_lo  (addr_lo_q),
      .funct3   (funct3_q),
      .merged   (merged),
      .be       (merge_be)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         st_ready  <= 1'b1;
         st_done   <= 1'b0;
         st_err    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef DM_BYTE_STROBE_EN
         mem_be    <= 4'b0000;
`endif
      end else begin
         st_done <= 1'b0;
         st_err  <= 1'b0;
         case (state)
            IDLE: if (st_valid) begin
               st_ready <= 1'b0;
               mem_addr <= st_addr[MEM_AW+1:2];
               if (store_err(st_funct3, st_addr[1:0])) begin
                  state  <= ERR;
                  st_err <= 1'b1;
`ifdef DM_BYTE_STROBE_EN
               end else begin
                  state     <= WR;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= merged;
                  mem_be    <= merge_be;
                  st_done   <= 1'b1;
               end
`else
               end else if (st_funct3 == F3_SW) begin
                  state     <= WR;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= st_wdata;
                  st_done   <= 1'b1;
               end else begin
                  state     <= RD;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  wdata_q   <= st_wdata;
                  addr_lo_q <= st_addr[1:0];
                  funct3_q  <= st_funct3;
               end
`endif
            end
            RD: begin
               state   <= WAIT;
               mem_req <= 1'b0;
            end
            WAIT: if (mem_rvalid) begin
               state     <= WR;
               mem_req   <= 1'b1;
               mem_we    <= 1'b1;
               mem_wdata <= merged;
               st_done   <= 1'b1;
            end
            WR: begin
               state    <= IDLE;
               st_ready <= 1'b1;
               mem_req  <= 1'b0;
               mem_we   <= 1'b0;
`ifdef DM_BYTE_STROBE_EN
               mem_be   <= 4'b0000;
`endif
            end
            ERR: begin
               state    <= IDLE;
               st_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               st_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_store_unit.sv
// tb/tb_dm_store_unit.sv - directed table-driven bench for dm_store_unit with a word memory model
// Also builds with DM_BYTE_STROBE_EN, where sub-word stores skip the read.
module tb_dm_store_unit;
   import dm_pkg::*;

`ifdef DM_BYTE_STROBE_EN
   localparam int RMW_LAT = 1;
   localparam int RMW_RDS = 0;
   localparam int GAP     = 2;
`else
   localparam int RMW_LAT = 3;
   localparam int RMW_RDS = 1;
   localparam int GAP     = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [31:0] st_wdata = '0;
   logic [2:0]  st_funct3 = '0;
   logic        st_done;
   logic        st_err;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
`ifdef DM_BYTE_STROBE_EN
   logic [3:0]  mem_be;
`endif

   dm_store_unit #(.MEM_AW(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .st_valid   (st_valid),
      .st_ready   (st_ready),
      .st_addr    (st_addr),
      .st_wdata   (st_wdata),
      .st_funct3  (st_funct3),
      .st_done    (st_done),
      .st_err     (st_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
`ifdef DM_BYTE_STROBE_EN
      .mem_be     (mem_be),
`endif
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   always #5 clk = ~clk;

   // Memory model: read data returns one cycle after a read strobe.
   logic [31:0] mem [0:1023];
   logic        model_rv = 1'b0;
   logic        force_rv = 1'b0;
   logic        resp_en = 1'b1;
   logic        pl_we = 1'b0;
   logic [9:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;

   assign mem_rvalid = model_rv | force_rv;

   always @(posedge clk) begin
      model_rv <= 1'b0;
      if (pl_we) mem[pl_idx] <= pl_data;
      if (mem_req && !mem_we) begin
         rd_cnt <= rd_cnt + 1;
         if (resp_en) begin
            model_rv  <= 1'b1;
            mem_rdata <= mem[mem_addr];
         end
      end
      if (mem_req && mem_we) begin
         wr_cnt <= wr_cnt + 1;
`ifdef DM_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
         mem[mem_addr] <= mem_wdata;
`endif
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      pl_idx  = idx;
      pl_data = val;
      pl_we   = 1'b1;
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic issue(input string name, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      bit ok = 0;
      st_addr   = a;
      st_wdata  = d;
      st_funct3 = f;
      st_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (st_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check({name, "_accept"}, 32'd0, 32'd1);
      @(posedge clk);
      #1 st_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f3;
      logic [31:0] init;
      logic        exp_err;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input vec_t v, input int n);
      int    lat = -1, rdy_at = -1, errs = 0, dones = 0, rd0, wr0, exp_lat, exp_rd;
      string nm;
      nm = $sformatf("v%0d", n);
      preload(v.addr[11:2], v.init);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(nm, v.addr, v.data, v.f3);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (st_done) begin dones++; if (lat < 0) lat = k; end
         if (st_err)  begin errs++;  if (lat < 0) lat = k; end
         if (st_ready && rdy_at < 0) rdy_at = k;
      end
      exp_lat = (v.exp_err || v.f3 == F3_SW) ? 1 : RMW_LAT;
      exp_rd  = (v.exp_err || v.f3 == F3_SW) ? 0 : RMW_RDS;
      check({nm, "_err"},   errs, {31'd0, v.exp_err});
      check({nm, "_done"},  dones, {31'd0, !v.exp_err});
      check({nm, "_lat"},   lat, exp_lat);
      check({nm, "_ready"}, rdy_at, exp_lat + 1);
      check({nm, "_reads"}, rd_cnt - rd0, exp_rd);
      check({nm, "_writes"}, wr_cnt - wr0, v.exp_err ? 0 : 1);
      check({nm, "_word"},  mem[v.addr[11:2]], v.exp_word);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int done_at, acc_at, wr0, seen;

      vecs[0]  = '{32'h101, 32'h000000AB, F3_SB,  32'h11223344, 1'b0, 32'h1122AB44};
      vecs[1]  = '{32'h102, 32'h0000BEEF, F3_SH,  32'h11223344, 1'b0, 32'hBEEF3344};
      vecs[2]  = '{32'h100, 32'hDEADBEEF, F3_SW,  32'h11223344, 1'b0, 32'hDEADBEEF};
      vecs[3]  = '{32'h103, 32'h0000BEEF, F3_SH,  32'h11223344, 1'b1, 32'h11223344};
      vecs[4]  = '{32'h100, 32'hDEADBEEF, 3'b011, 32'h11223344, 1'b1, 32'h11223344};
      vecs[5]  = '{32'h100, 32'hFFFFFF5A, F3_SB,  32'h11223344, 1'b0, 32'h1122335A};
      vecs[6]  = '{32'h103, 32'h00000077, F3_SB,  32'h11223344, 1'b0, 32'h77223344};
      vecs[7]  = '{32'h100, 32'hAAAA5566, F3_SH,  32'h11223344, 1'b0, 32'h11225566};
      vecs[8]  = '{32'h102, 32'h0BADF00D, F3_SW,  32'h11223344, 1'b1, 32'h11223344};
      vecs[9]  = '{32'h104, 32'h0BADF00D, F3_SW,  32'h99887766, 1'b0, 32'h0BADF00D};
      vecs[10] = '{32'h100, 32'h000000AB, 3'b100, 32'h11223344, 1'b1, 32'h11223344};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", {st_ready, st_done, st_err, mem_req, mem_we}, 32'b10000);
      check("reset_addr", mem_addr, 32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_ready", st_ready, 32'd1);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

`ifndef DM_BYTE_STROBE_EN
      // Reset while waiting for read data: the pending store must be dropped.
      preload(10'h40, 32'h11223344);
      resp_en = 1'b0;
      wr0 = wr_cnt;
      issue("rst", 32'h101, 32'h000000AB, F3_SB);
      @(negedge clk);
      check("rst_rd_cycle", {mem_req, mem_we}, 32'b10);
      check("rst_rd_addr", mem_addr, 32'h40);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_ctl", {st_ready, st_done, st_err, mem_req, mem_we}, 32'b10000);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      resp_en  = 1'b1;
      force_rv = 1'b1;
      @(negedge clk);
      force_rv = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_req || st_done || !st_ready) seen++;
      end
      check("rst_late_rvalid", seen, 32'd0);
      check("rst_no_write", wr_cnt - wr0, 32'd0);
      check("rst_word", mem[10'h40], 32'h11223344);
`endif

      // Second request held on st_valid while the first store is in flight.
      preload(10'h40, 32'h11223344);
      preload(10'h41, 32'hAABBCCDD);
      wr0 = wr_cnt;
      done_at = -1;
      acc_at = -1;
      issue("b2b", 32'h101, 32'h000000AB, F3_SB);
      st_addr   = 32'h106;
      st_wdata  = 32'h00001357;
      st_funct3 = F3_SH;
      st_valid  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (st_done && done_at < 0) done_at = k;
         if (st_ready) begin
            acc_at = k;
            @(posedge clk);
            #1 st_valid = 1'b0;
            break;
         end
      end
      st_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("b2b_accept_gap", acc_at, GAP);
      check("b2b_done_first", (done_at > 0 && done_at < acc_at) ? 32'd1 : 32'd0, 32'd1);
      check("b2b_word0", mem[10'h40], 32'h1122AB44);
      check("b2b_word1", mem[10'h41], 32'h1357CCDD);
      check("b2b_writes", wr_cnt - wr0, 32'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
